// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported unified memory between the
// fetch port (IF) and the data port (DM). DM normally wins; a fairness
// counter lets IF through after FAIR_LIMIT consecutive DM grants.
// The granted command is registered and held until mem_ack. A one-cycle
// ready pulse then returns the read data to the granted port.
// Optional feature: define ARB_WATCHDOG_EN to abort transactions that
// stall for MAX_WAIT cycles (ready with rdata=0, sticky err).
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FAIR_LIMIT = 4,
  parameter int MAX_WAIT   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
);

  localparam int              FC_W     = $clog2(FAIR_LIMIT + 1);
  localparam logic [FC_W-1:0] FAIR_MAX = FC_W'(FAIR_LIMIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IF   = 2'd1,
    GNT_DM   = 2'd2
  } grant_t;

  state_t            state_r, state_nxt_s;
  grant_t            grant_r, grant_nxt_s;
  logic [FC_W-1:0]   fair_cnt_r, fair_nxt_s;
  logic              mem_req_r, mem_req_nxt_s;
  logic              mem_we_r, mem_we_nxt_s;
  logic [ADDR_W-1:0] mem_addr_r, mem_addr_nxt_s;
  logic [DATA_W-1:0] mem_wdata_r, mem_wdata_nxt_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_nxt_s;
  logic [DATA_W-1:0] dm_rdata_r, dm_rdata_nxt_s;
  logic              if_ready_r, if_ready_nxt_s;
  logic              dm_ready_r, dm_ready_nxt_s;
  logic              dm_wins_s;
  logic              timeout_s;
  logic [DATA_W-1:0] rsp_data_s;

  // DM wins unless IF is also waiting and DM has used up its fairness budget
  assign dm_wins_s  = dm_req && (!if_req || (fair_cnt_r < FAIR_MAX));
  // an aborted transaction returns zero instead of memory data
  assign rsp_data_s = mem_ack ? mem_rdata : '0;

  // Next-state, grant, fairness and output-register computation
  always_comb begin
    state_nxt_s     = state_r;
    grant_nxt_s     = grant_r;
    fair_nxt_s      = fair_cnt_r;
    mem_req_nxt_s   = mem_req_r;
    mem_we_nxt_s    = mem_we_r;
    mem_addr_nxt_s  = mem_addr_r;
    mem_wdata_nxt_s = mem_wdata_r;
    if_rdata_nxt_s  = if_rdata_r;
    dm_rdata_nxt_s  = dm_rdata_r;
    if_ready_nxt_s  = 1'b0;
    dm_ready_nxt_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (dm_wins_s) begin
          state_nxt_s     = ST_BUSY;
          grant_nxt_s     = GNT_DM;
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = dm_we;
          mem_addr_nxt_s  = dm_addr;
          mem_wdata_nxt_s = dm_wdata;
          if (if_req) begin
            if (fair_cnt_r < FAIR_MAX) begin
              fair_nxt_s = fair_cnt_r + FC_W'(1);
            end else begin
              fair_nxt_s = FAIR_MAX;
            end
          end else begin
            fair_nxt_s = '0;
          end
        end else if (if_req) begin
          state_nxt_s     = ST_BUSY;
          grant_nxt_s     = GNT_IF;
          mem_req_nxt_s   = 1'b1;
          mem_we_nxt_s    = 1'b0;
          mem_addr_nxt_s  = if_addr;
          mem_wdata_nxt_s = '0;
          fair_nxt_s      = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ack || timeout_s) begin
          state_nxt_s   = ST_RESP;
          mem_req_nxt_s = 1'b0;
          if (grant_r == GNT_IF) begin
            if_ready_nxt_s = 1'b1;
            if_rdata_nxt_s = rsp_data_s;
          end else if (grant_r == GNT_DM) begin
            dm_ready_nxt_s = 1'b1;
            dm_rdata_nxt_s = rsp_data_s;
          end else begin
            grant_nxt_s = GNT_NONE;
          end
        end else begin
          state_nxt_s = ST_BUSY;
        end
      end
      ST_RESP: begin
        // requests are deliberately not evaluated here
        state_nxt_s = ST_IDLE;
        grant_nxt_s = GNT_NONE;
      end
      default: begin
        state_nxt_s   = ST_IDLE;
        grant_nxt_s   = GNT_NONE;
        mem_req_nxt_s = 1'b0;
      end
    endcase
  end

  // FSM state and grant register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      grant_r    <= GNT_NONE;
      fair_cnt_r <= '0;
    end else begin
      state_r    <= state_nxt_s;
      grant_r    <= grant_nxt_s;
      fair_cnt_r <= fair_nxt_s;
    end
  end

  // Registered memory command and per-port response outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      if_rdata_r  <= '0;
      dm_rdata_r  <= '0;
      if_ready_r  <= 1'b0;
      dm_ready_r  <= 1'b0;
    end else begin
      mem_req_r   <= mem_req_nxt_s;
      mem_we_r    <= mem_we_nxt_s;
      mem_addr_r  <= mem_addr_nxt_s;
      mem_wdata_r <= mem_wdata_nxt_s;
      if_rdata_r  <= if_rdata_nxt_s;
      dm_rdata_r  <= dm_rdata_nxt_s;
      if_ready_r  <= if_ready_nxt_s;
      dm_ready_r  <= dm_ready_nxt_s;
    end
  end

`ifdef ARB_WATCHDOG_EN
  localparam int                WAIT_W    = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [WAIT_W-1:0] wait_cnt_r;
  logic              err_r;

  // abort in the BUSY cycle that would bring the stall count to MAX_WAIT
  assign timeout_s = (state_r == ST_BUSY) && !mem_ack && (wait_cnt_r == WAIT_LAST);

  // Stall counter: held at zero outside BUSY so every grant starts from zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_r <= '0;
    end else if ((state_r == ST_BUSY) && !mem_ack) begin
      wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
    end else begin
      wait_cnt_r <= '0;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | timeout_s;
    end
  end

  assign err = err_r;
`else
  // without the watchdog BUSY waits for mem_ack indefinitely
  logic [31:0] unused_max_wait_s;
  assign unused_max_wait_s = 32'(MAX_WAIT);
  assign timeout_s         = 1'b0;
  assign err               = 1'b0;
`endif

  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign if_rdata  = if_rdata_r;
  assign if_ready  = if_ready_r;
  assign dm_rdata  = dm_rdata_r;
  assign dm_ready  = dm_ready_r;

endmodule
